// File: rtl/seq_signed_divider.sv
`timescale 1ns/1ps
`default_nettype none
// seq_signed_divider: multi-cycle signed divider (2N-bit dividend / N-bit divisor),
// radix-2 restoring division on magnitudes followed by a sign fix-up cycle.
module seq_signed_divider #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(2*N+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [N-1:0]    prem;
    logic [N-1:0]    dmag;
    logic [2*N-1:0]  qacc;
    logic            neg_q;
    logic            neg_r;
    logic            dz_pend;
    logic            ovf_pend;

    logic [2*N-1:0]  dividend_mag;
    logic [N-1:0]    divisor_mag;
    logic [N:0]      shifted;
    logic [N:0]      diff;
    logic [2*N-1:0]  q_fixed;
    logic [N-1:0]    r_fixed;

    assign dividend_mag = dividend[2*N-1] ? ({(2*N){1'b0}} - dividend) : dividend;
    assign divisor_mag  = divisor[N-1]    ? ({N{1'b0}} - divisor)      : divisor;

    // qacc holds the remaining dividend bits in its top and collects quotient bits at its bottom.
    assign shifted = {prem, qacc[2*N-1]};
    assign diff    = shifted - {1'b0, dmag};

    always_comb begin
        q_fixed = neg_q ? ({(2*N){1'b0}} - qacc) : qacc;
        r_fixed = neg_r ? ({N{1'b0}} - prem) : prem;
        if (dz_pend) begin
            q_fixed = {(2*N){1'b1}};
            r_fixed = '0;
        end else if (ovf_pend) begin
            q_fixed = {1'b1, {(2*N-1){1'b0}}};
            r_fixed = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            prem        <= '0;
            dmag        <= '0;
            qacc        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_pend     <= 1'b0;
            ovf_pend    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        qacc        <= dividend_mag;
                        dmag        <= divisor_mag;
                        prem        <= '0;
                        count       <= CW'(2*N);
                        neg_q       <= dividend[2*N-1] ^ divisor[N-1];
                        neg_r       <= dividend[2*N-1];
                        dz_pend     <= (divisor == '0);
                        ovf_pend    <= (dividend == {1'b1, {(2*N-1){1'b0}}}) && (divisor == '1);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                CALC: begin
                    prem  <= diff[N] ? shifted[N-1:0] : diff[N-1:0];
                    qacc  <= {qacc[2*N-2:0], ~diff[N]};
                    count <= count - CW'(1);
                end
                FIX: begin
                    quotient    <= q_fixed;
                    remainder   <= r_fixed;
                    div_by_zero <= dz_pend;
                    overflow    <= ovf_pend;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
